systolic_array: RTL and testbench

4x4 weight-stationary systolic matrix-multiply engine with on-chip operand and result storage. A host byte-loads a weight matrix and a feature matrix, then holds `ena` high. The block preloads the weights into the PE grid, streams skewed feature vectors through it, and saturates each column sum to 8 bits. Each column sum is thresholded and written as a 32-bit row into a writeback memory that the host reads back.

---
 rtl/systolic_array_if.sv | 21 ++
 rtl/systolic_array.sv | 180 ++++++++++++++++++
 tb/tb_systolic_array.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_if.sv
// Host-side bus of the 4x4 systolic matrix-multiply engine: byte writes,
// run enable, writeback readout and completion flag.
interface systolic_array_if;
  logic        we;
  logic        ena;
  logic [1:0]  sel;
  logic [3:0]  addr;
  logic [7:0]  data_in;
  logic [31:0] data_out;
  logic        done;

  modport master (
    output we, ena, sel, addr, data_in,
    input  data_out, done
  );

  modport slave (
    input  we, ena, sel, addr, data_in,
    output data_out, done
  );
endinterface

// File: rtl/systolic_array.sv
// 4x4 weight-stationary systolic multiplier: weight preload, skewed feature
// streaming, 8-bit saturation, deskew, threshold activation and writeback.
module systolic_array (
  input logic             clk,
  input logic             reset,
  systolic_array_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        w_run, w_clear, w_preload, w_wb_en;
  logic [1:0]  w_pre_row, w_wb_row;
  logic [4:0]  w_nn;

  logic [31:0] r_wmem  [4];
  logic [31:0] r_fmem  [4];
  logic [31:0] r_wbmem [4];
  logic [7:0]  r_thr;

  logic [7:0]  r_w  [4][4];
  logic [7:0]  r_a  [4][4];
  logic [31:0] r_ps [4][4];
  logic [7:0]  w_w_src  [4][4];
  logic [7:0]  w_a_src  [4][4];
  logic [31:0] w_ps_src [4][4];

  logic [7:0]  r_skew [4];
  logic [7:0]  w_skew_next [4];
  logic [7:0]  r_d0 [3];
  logic [7:0]  r_d1 [2];
  logic [7:0]  r_d2;
  logic [7:0]  w_q [4];
  logic [7:0]  w_al [4];
  logic [31:0] w_wb_word;

  // Sequencer: ena low always forces idle and clears the array on the next edge.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_clear      = 1'b0;
    w_run        = 1'b0;
    if (!bus.ena) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_clear      = 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_RUN: begin
          w_run        = 1'b1;
          w_cnt_next   = r_cnt + 4'd1;
          w_state_next = (r_cnt == 4'd14) ? S_DONE : S_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign w_preload = w_run && (r_cnt < 4'd4);
  assign w_wb_en   = w_run && (r_cnt >= 4'd11) && (r_cnt <= 4'd14);
  assign w_pre_row = ~r_cnt[1:0];
  assign w_wb_row  = 2'(r_cnt - 4'd11);
  assign bus.done  = (r_state == S_DONE);
  assign bus.data_out = r_wbmem[bus.addr[1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_wmem[i] <= '0;
        r_fmem[i] <= '0;
      end
      r_thr <= '0;
    end else if (bus.we && !bus.ena) begin
      case (bus.sel)
        2'd0: r_wmem[bus.addr[3:2]][{bus.addr[1:0], 3'b000} +: 8] <= bus.data_in;
        2'd1: r_fmem[bus.addr[3:2]][{bus.addr[1:0], 3'b000} +: 8] <= bus.data_in;
        2'd2: r_thr <= bus.data_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        w_w_src[r][c]  = '0;
        w_a_src[r][c]  = '0;
        w_ps_src[r][c] = '0;
      end
    end
    for (int unsigned c = 0; c < 4; c++)
      w_w_src[0][c] = r_wmem[w_pre_row][8*c +: 8];
    for (int unsigned r = 1; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        w_w_src[r][c]  = r_w[r-1][c];
        w_ps_src[r][c] = r_ps[r-1][c];
      end
    end
    for (int unsigned r = 0; r < 4; r++) begin
      w_a_src[r][0] = r_skew[r];
      for (int unsigned c = 1; c < 4; c++)
        w_a_src[r][c] = r_a[r][c-1];
    end
  end

  // Skew register r is loaded for the next cycle's n: feature k byte r when n == k + r.
  always_comb begin
    w_nn = {1'b0, r_cnt} - 5'd3;
    for (int unsigned r = 0; r < 4; r++) begin
      w_skew_next[r] = '0;
      for (int unsigned k = 0; k < 4; k++) begin
        if (r_cnt >= 4'd3 && w_nn == 5'(k + r))
          w_skew_next[r] = r_fmem[k][8*r +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      for (int unsigned r = 0; r < 4; r++) begin
        for (int unsigned c = 0; c < 4; c++) begin
          r_w[r][c]  <= '0;
          r_a[r][c]  <= '0;
          r_ps[r][c] <= '0;
        end
        r_skew[r] <= '0;
      end
      for (int unsigned i = 0; i < 3; i++) r_d0[i] <= '0;
      for (int unsigned i = 0; i < 2; i++) r_d1[i] <= '0;
      r_d2 <= '0;
    end else if (w_run) begin
      for (int unsigned r = 0; r < 4; r++) begin
        for (int unsigned c = 0; c < 4; c++) begin
          if (w_preload) r_w[r][c] <= w_w_src[r][c];
          r_a[r][c]  <= w_a_src[r][c];
          r_ps[r][c] <= ({24'd0, w_a_src[r][c]} * {24'd0, r_w[r][c]}) + w_ps_src[r][c];
        end
        r_skew[r] <= w_skew_next[r];
      end
      r_d0[0] <= w_q[0];
      r_d0[1] <= r_d0[0];
      r_d0[2] <= r_d0[1];
      r_d1[0] <= w_q[1];
      r_d1[1] <= r_d1[0];
      r_d2    <= w_q[2];
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < 4; c++)
      w_q[c] = (|r_ps[3][c][31:8]) ? 8'hff : r_ps[3][c][7:0];
    w_al[0] = r_d0[2];
    w_al[1] = r_d1[1];
    w_al[2] = r_d2;
    w_al[3] = w_q[3];
    w_wb_word = '0;
    for (int unsigned c = 0; c < 4; c++)
      w_wb_word[8*c +: 8] = (w_al[c] >= r_thr) ? w_al[c] : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) r_wbmem[i] <= '0;
    end else if (w_wb_en) begin
      r_wbmem[w_wb_row] <= w_wb_word;
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// Bench for systolic_array: spec vectors, gating/abort/reset sequences and
// random matrices checked against a plain matrix-product model.
module tb_systolic_array;
  logic clk = 1'b0;
  logic reset;
  systolic_array_if bus();

  systolic_array dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] cur_w [4];
  logic [31:0] cur_f [4];
  logic [7:0]  cur_thr;

  typedef struct {
    logic [31:0] w   [4];
    logic [31:0] f   [4];
    logic [7:0]  thr;
    logic [31:0] exp [4];
  } vec_t;
  vec_t tbl [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] s, input logic [3:0] a, input logic [7:0] d);
    bus.we = 1'b1; bus.sel = s; bus.addr = a; bus.data_in = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic load_cur();
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < 4; b++) begin
        wr(2'd0, 4'(r*4 + b), cur_w[r][8*b +: 8]);
        wr(2'd1, 4'(r*4 + b), cur_f[r][8*b +: 8]);
      end
    wr(2'd2, 4'd0, cur_thr);
  endtask

  function automatic logic [31:0] model_row(input int k);
    logic [31:0] res;
    int unsigned s;
    logic [7:0]  q;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      s = 0;
      for (int r = 0; r < 4; r++)
        s += int'(cur_f[k][8*r +: 8]) * int'(cur_w[r][8*c +: 8]);
      q = (s > 255) ? 8'hff : s[7:0];
      if (q < cur_thr) q = 8'd0;
      res[8*c +: 8] = q;
    end
    return res;
  endfunction

  task automatic read_row(input int k, output logic [31:0] v);
    bus.addr = 4'(k);
    #1;
    v = bus.data_out;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) begin
      read_row(k, v);
      check($sformatf("%s_row%0d", tag, k), v, model_row(k));
    end
  endtask

  task automatic stop_run(input string tag);
    bus.ena = 1'b0;
    tick();
    check({tag, "_done_clear"}, 32'(bus.done), 32'd0);
  endtask

  task automatic run_until_done(input string tag);
    int n;
    n = 0;
    bus.ena = 1'b1;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'd15);
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1;
    bus.we = 1'b0; bus.ena = 1'b0; bus.sel = 2'd0; bus.addr = 4'd0; bus.data_in = 8'd0;
    tick(); tick();
    reset = 1'b0;
    tick();

    for (int k = 0; k < 4; k++) begin
      read_row(k, v);
      check($sformatf("reset_row%0d", k), v, 32'd0);
    end
    check("reset_done", 32'(bus.done), 32'd0);

    for (int r = 0; r < 4; r++) tbl[0].w[r] = 32'h04030201;
    tbl[0].f[0] = 32'h01020004; tbl[0].f[1] = 32'h00020304;
    tbl[0].f[2] = 32'h01000304; tbl[0].f[3] = 32'h01020304;
    tbl[0].thr  = 8'h0a;
    tbl[0].exp[0] = 32'h1c150e00; tbl[0].exp[1] = 32'h241b1200;
    tbl[0].exp[2] = 32'h20181000; tbl[0].exp[3] = 32'h281e140a;
    tbl[1] = tbl[0];
    tbl[1].thr  = 8'h00;
    tbl[1].exp[0] = 32'h1c150e07; tbl[1].exp[1] = 32'h241b1209;
    tbl[1].exp[2] = 32'h20181008; tbl[1].exp[3] = 32'h281e140a;
    for (int r = 0; r < 4; r++) begin
      tbl[2].w[r] = 32'hffffffff; tbl[2].f[r] = 32'hffffffff; tbl[2].exp[r] = 32'hffffffff;
    end
    tbl[2].thr = 8'h00;

    for (int i = 0; i < 3; i++) begin
      cur_w = tbl[i].w; cur_f = tbl[i].f; cur_thr = tbl[i].thr;
      load_cur();
      bus.ena = 1'b1;
      repeat (14) tick();
      check($sformatf("tbl%0d_done_early", i), 32'(bus.done), 32'd0);
      tick();
      check($sformatf("tbl%0d_done_edge", i), 32'(bus.done), 32'd1);
      repeat (7) tick();
      for (int k = 0; k < 4; k++) begin
        read_row(k, v);
        check($sformatf("tbl%0d_row%0d", i, k), v, tbl[i].exp[k]);
      end
      check($sformatf("tbl%0d_done_hold", i), 32'(bus.done), 32'd1);
      stop_run($sformatf("tbl%0d", i));
    end

    // Writes with sel=3, and any writes while ena=1, must leave everything intact.
    cur_w = tbl[0].w; cur_f = tbl[0].f; cur_thr = tbl[0].thr;
    load_cur();
    wr(2'd3, 4'd0, 8'hff);
    bus.ena = 1'b1;
    bus.we = 1'b1; bus.addr = 4'd0; bus.data_in = 8'hff;
    bus.sel = 2'd0; tick();
    bus.sel = 2'd1; tick();
    bus.sel = 2'd2; tick();
    bus.we = 1'b0;
    repeat (19) tick();
    for (int k = 0; k < 4; k++) begin
      read_row(k, v);
      check($sformatf("gate_row%0d", k), v, tbl[0].exp[k]);
    end
    stop_run("gate");
    run_until_done("gate_rerun");
    check_model("gate_rerun");
    stop_run("gate_rerun");

    // Abort after rows 0 and 1 are written.
    reset = 1'b1; tick(); reset = 1'b0;
    load_cur();
    bus.ena = 1'b1;
    repeat (13) tick();
    bus.ena = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      read_row(k, v);
      check($sformatf("abort_row%0d", k), v, (k < 2) ? tbl[0].exp[k] : 32'd0);
    end
    check("abort_done", 32'(bus.done), 32'd0);
    run_until_done("abort_rerun");
    for (int k = 0; k < 4; k++) begin
      read_row(k, v);
      check($sformatf("abort_rerun_row%0d", k), v, tbl[0].exp[k]);
    end
    stop_run("abort_rerun");

    for (int it = 0; it < 6; it++) begin
      int mode;
      mode = int'($urandom_range(0, 1));
      for (int r = 0; r < 4; r++)
        for (int b = 0; b < 4; b++) begin
          cur_w[r][8*b +: 8] = (mode != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
          cur_f[r][8*b +: 8] = (mode != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
        end
      cur_thr = 8'($urandom_range(0, 63));
      load_cur();
      run_until_done($sformatf("rnd%0d", it));
      check_model($sformatf("rnd%0d", it));
      stop_run($sformatf("rnd%0d", it));
    end

    // Reset mid-run: row 0 already written at this point and must be wiped.
    load_cur();
    bus.ena = 1'b1;
    repeat (12) tick();
    reset = 1'b1; bus.ena = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      read_row(k, v);
      check($sformatf("midreset_row%0d", k), v, 32'd0);
    end
    check("midreset_done", 32'(bus.done), 32'd0);

    // Reset after a completed run.
    load_cur();
    run_until_done("final");
    reset = 1'b1; bus.ena = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.addr = 4'(k);
      #1;
      check($sformatf("postreset_addr%0d", k), bus.data_out, 32'd0);
    end
    check("postreset_done", 32'(bus.done), 32'd0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check($sformatf("postreset_w%0d%0d", r, c), 32'(dut.r_w[r][c]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
